// File: rtl/dmi_req_bridge.sv
// Core-clock bridge from DMI wrapper register strobes to a valid/ready request
// and response transaction, with timeout, overrun detection and hard-reset abort.
module dmi_req_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 7,
   parameter int DATA_W         = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dmi_reg_en,
   input  logic              dmi_reg_wr_en,
   input  logic [ADDR_W-1:0] dmi_reg_addr,
   input  logic [DATA_W-1:0] dmi_reg_wdata,
   input  logic              dmi_hard_reset,
   output logic [DATA_W-1:0] dmi_reg_rdata,
   output logic              dbg_req_valid,
   input  logic              dbg_req_ready,
   output logic              dbg_req_write,
   output logic [ADDR_W-1:0] dbg_req_addr,
   output logic [DATA_W-1:0] dbg_req_wdata,
   input  logic              dbg_rsp_valid,
   input  logic [DATA_W-1:0] dbg_rsp_data,
   input  logic              dbg_rsp_err,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun,
   output logic              err_rsp
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] T_VAL   = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_REQ = 2'd1,
      WAIT_RSP = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next, cnt_inc;
   logic          latch_req, rdata_upd, set_timeout, set_overrun, set_rsp;
   logic          timeout_hit;

   // Next-state, counter and flag-set decode; hard reset overrides everything.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      latch_req   = 1'b0;
      rdata_upd   = 1'b0;
      set_timeout = 1'b0;
      set_rsp     = 1'b0;
      set_overrun = dmi_reg_en && (state != IDLE);
      cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
      timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_inc == T_VAL);

      case (state)
         IDLE: begin
            if (dmi_reg_en) begin
               latch_req  = 1'b1;
               state_next = SEND_REQ;
               cnt_next   = '0;
            end else begin
               cnt_next   = '0;
            end
         end
         SEND_REQ: begin
            if (dbg_req_ready) begin
               state_next = WAIT_RSP;
               cnt_next   = '0;
            end else if (timeout_hit) begin
               set_timeout = 1'b1;
               state_next  = IDLE;
               cnt_next    = '0;
            end else begin
               cnt_next    = cnt_inc;
            end
         end
         WAIT_RSP: begin
            if (dbg_rsp_valid) begin
               state_next = IDLE;
               cnt_next   = '0;
               rdata_upd  = !dbg_req_write;
               set_rsp    = dbg_rsp_err;
            end else if (timeout_hit) begin
               set_timeout = 1'b1;
               state_next  = IDLE;
               cnt_next    = '0;
            end else begin
               cnt_next    = cnt_inc;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      if (dmi_hard_reset) begin
         state_next = IDLE;
         cnt_next   = '0;
         latch_req  = 1'b0;
         rdata_upd  = 1'b0;
      end else begin
         state_next = state_next;
      end
   end

   // State, counter, request/response registers and sticky flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         busy          <= 1'b0;
         dbg_req_valid <= 1'b0;
         dbg_req_write <= 1'b0;
         dbg_req_addr  <= '0;
         dbg_req_wdata <= '0;
         dmi_reg_rdata <= '0;
         err_timeout   <= 1'b0;
         err_overrun   <= 1'b0;
         err_rsp       <= 1'b0;
      end else begin
         state         <= state_next;
         cnt           <= cnt_next;
         busy          <= (state_next != IDLE);
         dbg_req_valid <= (state_next == SEND_REQ);
         if (latch_req) begin
            dbg_req_write <= dmi_reg_wr_en;
            dbg_req_addr  <= dmi_reg_addr;
            dbg_req_wdata <= dmi_reg_wdata;
         end
         if (rdata_upd) begin
            dmi_reg_rdata <= dbg_rsp_data;
         end
         // Clear beats a simultaneous set.
         if (dmi_hard_reset) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_rsp     <= 1'b0;
         end else begin
            err_timeout <= err_timeout | set_timeout;
            err_overrun <= err_overrun | set_overrun;
            err_rsp     <= err_rsp | set_rsp;
         end
      end
   end

endmodule

// File: tb/tb_dmi_req_bridge.sv
// Directed self-checking bench for dmi_req_bridge (TIMEOUT_CYCLES = 8).
module tb_dmi_req_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic        dmi_reg_en, dmi_reg_wr_en, dmi_hard_reset;
   logic [6:0]  dmi_reg_addr;
   logic [31:0] dmi_reg_wdata, dmi_reg_rdata;
   logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
   logic [6:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata;
   logic        dbg_rsp_valid, dbg_rsp_err;
   logic [31:0] dbg_rsp_data;
   logic        busy, err_timeout, err_overrun, err_rsp;

   int total = 0;
   int bad   = 0;

   dmi_req_bridge #(.TIMEOUT_CYCLES(8), .ADDR_W(7), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .dmi_reg_en(dmi_reg_en), .dmi_reg_wr_en(dmi_reg_wr_en),
      .dmi_reg_addr(dmi_reg_addr), .dmi_reg_wdata(dmi_reg_wdata),
      .dmi_hard_reset(dmi_hard_reset), .dmi_reg_rdata(dmi_reg_rdata),
      .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
      .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
      .dbg_req_wdata(dbg_req_wdata), .dbg_rsp_valid(dbg_rsp_valid),
      .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
      .busy(busy), .err_timeout(err_timeout),
      .err_overrun(err_overrun), .err_rsp(err_rsp)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_flags(input string tag, input logic [31:0] to, input logic [31:0] ov,
                              input logic [31:0] rs);
      check_eq({tag, "_err_timeout"}, 32'(err_timeout), to);
      check_eq({tag, "_err_overrun"}, 32'(err_overrun), ov);
      check_eq({tag, "_err_rsp"},     32'(err_rsp),     rs);
   endtask

   task automatic issue(input logic wr, input logic [6:0] addr, input logic [31:0] wdata);
      dmi_reg_en = 1'b1; dmi_reg_wr_en = wr; dmi_reg_addr = addr; dmi_reg_wdata = wdata;
      tick();
      dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; dmi_reg_en = 1'b0; dmi_reg_wr_en = 1'b0; dmi_hard_reset = 1'b0;
      dmi_reg_addr = 7'h00; dmi_reg_wdata = 32'h0; dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b0; dbg_rsp_data = 32'h0; dbg_rsp_err = 1'b0;
      tick(); tick();
      check_eq("rst_valid", 32'(dbg_req_valid), 32'd0);
      check_eq("rst_busy",  32'(busy), 32'd0);
      check_eq("rst_rdata", dmi_reg_rdata, 32'h0);
      check_eq("rst_addr",  32'(dbg_req_addr), 32'h0);
      check_flags("rst", 32'd0, 32'd0, 32'd0);
      reset = 1'b0;
      tick();

      // Write with 5 cycles of backpressure
      issue(1'b1, 7'h10, 32'h8000_0001);
      for (int i = 0; i < 6; i++) begin
         check_eq("wr_valid", 32'(dbg_req_valid), 32'd1);
         check_eq("wr_addr",  32'(dbg_req_addr), 32'h10);
         check_eq("wr_wdata", dbg_req_wdata, 32'h8000_0001);
         check_eq("wr_write", 32'(dbg_req_write), 32'd1);
         dbg_req_ready = (i == 5);
         tick();
      end
      dbg_req_ready = 1'b0;
      check_eq("wr_valid_drop", 32'(dbg_req_valid), 32'd0);
      check_eq("wr_busy_wait", 32'(busy), 32'd1);
      dbg_rsp_valid = 1'b1; dbg_rsp_data = 32'h5555_AAAA;
      tick();
      dbg_rsp_valid = 1'b0;
      check_eq("wr_rdata", dmi_reg_rdata, 32'h0);
      check_eq("wr_busy_done", 32'(busy), 32'd0);
      check_flags("wr", 32'd0, 32'd0, 32'd0);

      // Read, ready in first SEND_REQ cycle, response a few cycles later
      issue(1'b0, 7'h11, 32'h0);
      check_eq("rd_valid", 32'(dbg_req_valid), 32'd1);
      check_eq("rd_addr",  32'(dbg_req_addr), 32'h11);
      check_eq("rd_write", 32'(dbg_req_write), 32'd0);
      dbg_req_ready = 1'b1;
      tick();
      dbg_req_ready = 1'b0;
      check_eq("rd_valid_1cyc", 32'(dbg_req_valid), 32'd0);
      tick(); tick();
      check_eq("rd_busy_wait", 32'(busy), 32'd1);
      dbg_rsp_valid = 1'b1; dbg_rsp_data = 32'h0003_0382;
      tick();
      dbg_rsp_valid = 1'b0;
      check_eq("rd_rdata", dmi_reg_rdata, 32'h0003_0382);
      check_eq("rd_busy_done", 32'(busy), 32'd0);

      // Timeout: no ready, 8 busy cycles
      issue(1'b0, 7'h05, 32'h0);
      for (int i = 0; i < 7; i++) begin
         check_eq("to_busy", 32'(busy), 32'd1);
         check_eq("to_flag_early", 32'(err_timeout), 32'd0);
         tick();
      end
      check_eq("to_busy_last", 32'(busy), 32'd1);
      tick();
      check_eq("to_busy_end", 32'(busy), 32'd0);
      check_eq("to_valid_end", 32'(dbg_req_valid), 32'd0);
      check_eq("to_flag", 32'(err_timeout), 32'd1);
      check_eq("to_rdata", dmi_reg_rdata, 32'h0003_0382);
      issue(1'b0, 7'h06, 32'h0);
      dbg_req_ready = 1'b1; tick(); dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b1; dbg_rsp_data = 32'h1234_5678; tick(); dbg_rsp_valid = 1'b0;
      check_eq("to_next_rdata", dmi_reg_rdata, 32'h1234_5678);
      check_eq("to_sticky", 32'(err_timeout), 32'd1);

      // Overrun in WAIT_RSP
      issue(1'b0, 7'h22, 32'h0);
      dbg_req_ready = 1'b1; tick(); dbg_req_ready = 1'b0;
      issue(1'b0, 7'h33, 32'h0);
      check_eq("ov_flag", 32'(err_overrun), 32'd1);
      check_eq("ov_addr", 32'(dbg_req_addr), 32'h22);
      check_eq("ov_valid", 32'(dbg_req_valid), 32'd0);
      dbg_rsp_valid = 1'b1; dbg_rsp_data = 32'hA5A5_A5A5; tick(); dbg_rsp_valid = 1'b0;
      check_eq("ov_rdata", dmi_reg_rdata, 32'hA5A5_A5A5);
      tick();
      check_eq("ov_no_second", 32'(dbg_req_valid), 32'd0);
      check_eq("ov_idle", 32'(busy), 32'd0);

      // Hard reset mid-WAIT_RSP with sticky flags set
      issue(1'b0, 7'h01, 32'h0);
      dbg_req_ready = 1'b1; tick(); dbg_req_ready = 1'b0;
      dmi_hard_reset = 1'b1; tick(); dmi_hard_reset = 1'b0;
      check_eq("hr_busy", 32'(busy), 32'd0);
      check_flags("hr", 32'd0, 32'd0, 32'd0);
      check_eq("hr_rdata", dmi_reg_rdata, 32'hA5A5_A5A5);
      tick();
      dbg_rsp_valid = 1'b1; dbg_rsp_data = 32'hFFFF_0000; tick(); dbg_rsp_valid = 1'b0;
      check_eq("hr_late_rsp", dmi_reg_rdata, 32'hA5A5_A5A5);
      check_eq("hr_late_busy", 32'(busy), 32'd0);

      // Error response on a read, then en together with hard reset
      issue(1'b0, 7'h17, 32'h0);
      dbg_req_ready = 1'b1; tick(); dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b1; dbg_rsp_err = 1'b1; dbg_rsp_data = 32'hDEAD_BEEF;
      tick();
      dbg_rsp_valid = 1'b0; dbg_rsp_err = 1'b0;
      check_eq("er_flag", 32'(err_rsp), 32'd1);
      check_eq("er_rdata", dmi_reg_rdata, 32'hDEAD_BEEF);
      dmi_hard_reset = 1'b1;
      issue(1'b0, 7'h2A, 32'h0);
      dmi_hard_reset = 1'b0;
      check_eq("hr_en_valid", 32'(dbg_req_valid), 32'd0);
      check_eq("hr_en_busy", 32'(busy), 32'd0);
      check_eq("hr_en_addr", 32'(dbg_req_addr), 32'h17);
      check_flags("hr_en", 32'd0, 32'd0, 32'd0);
      tick();
      check_eq("hr_en_valid_later", 32'(dbg_req_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
